// File: rtl/id_scoreboard_if.sv
// Decode-side bundle for the register-dependency scoreboard: issue, load-return,
// retire and source-lookup inputs plus the hazard/status outputs.
interface id_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int TOT_W  = 7
);
    logic              flush;
    logic              issue_valid;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_waddr;
    logic              issue_is_load;
    logic              ld_ret_valid;
    logic [ADDR_W-1:0] ld_ret_waddr;
    logic              retire_valid;
    logic [ADDR_W-1:0] retire_waddr;
    logic              src1_used;
    logic [ADDR_W-1:0] src1_addr;
    logic              src2_used;
    logic [ADDR_W-1:0] src2_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              data_hazard;
    logic              load_hazard;
    logic              issue_block;
    logic [TOT_W-1:0]  inflight;
    logic              sb_err;

    modport master (
        output flush, issue_valid, issue_we, issue_waddr, issue_is_load,
               ld_ret_valid, ld_ret_waddr, retire_valid, retire_waddr,
               src1_used, src1_addr, src2_used, src2_addr, dst_addr,
        input  data_hazard, load_hazard, issue_block, inflight, sb_err
    );

    modport slave (
        input  flush, issue_valid, issue_we, issue_waddr, issue_is_load,
               ld_ret_valid, ld_ret_waddr, retire_valid, retire_waddr,
               src1_used, src1_addr, src2_used, src2_addr, dst_addr,
        output data_hazard, load_hazard, issue_block, inflight, sb_err
    );
endinterface

// File: rtl/id_scoreboard.sv
// Register-dependency scoreboard: counts in-flight writes per register, tracks
// unreturned loads, and reports RAW / load hazards to the decode stage.
module id_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int TOT_W  = 7
) (
    input  logic               clk,
    input  logic               resetn,
    id_scoreboard_if.slave     sb
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [CNT_W-1:0] cnt_r   [NREG];
    logic [NREG-1:0]  lpend_r;
    logic [TOT_W-1:0] tot_r;
    logic             err_r;

    logic [CNT_W-1:0] cnt_nxt_s [NREG];
    logic [NREG-1:0]  lpend_nxt_s;
    logic [TOT_W-1:0] tot_nxt_s;
    logic             err_nxt_s;
    logic             iss_s;
    logic             ret_s;
    logic             same_s;
    logic [NREG-1:0]  inc_s;
    logic [NREG-1:0]  dec_s;
    logic             iss_err_s;
    logic             ret_err_s;
    logic             hz1_s;
    logic             hz2_s;

    // Qualify issue/retire events; a same-register issue+retire pair nets out.
    always_comb begin
        iss_s     = sb.issue_valid & sb.issue_we & (sb.issue_waddr != ADDR_ZERO);
        ret_s     = sb.retire_valid & (sb.retire_waddr != ADDR_ZERO);
        same_s    = iss_s & ret_s & (sb.issue_waddr == sb.retire_waddr);
        inc_s     = {NREG{1'b0}};
        dec_s     = {NREG{1'b0}};
        iss_err_s = 1'b0;
        ret_err_s = 1'b0;
        if (iss_s && !same_s) begin
            if (cnt_r[sb.issue_waddr] == CNT_MAX) begin
                iss_err_s = 1'b1;
            end else begin
                inc_s[sb.issue_waddr] = 1'b1;
            end
        end else begin
            iss_err_s = 1'b0;
        end
        if (ret_s && !same_s) begin
            if (cnt_r[sb.retire_waddr] == CNT_ZERO) begin
                ret_err_s = 1'b1;
            end else begin
                dec_s[sb.retire_waddr] = 1'b1;
            end
        end else begin
            ret_err_s = 1'b0;
        end
    end

    // Next-state for counters and load-pending bits; a load issue beats any clear.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt_s[r] = cnt_r[r] + {{(CNT_W-1){1'b0}}, inc_s[r]}
                                    - {{(CNT_W-1){1'b0}}, dec_s[r]};
            if (iss_s && sb.issue_is_load && (sb.issue_waddr == r[ADDR_W-1:0])) begin
                lpend_nxt_s[r] = 1'b1;
            end else if ((iss_s && (sb.issue_waddr == r[ADDR_W-1:0]))
                      || (sb.ld_ret_valid && (sb.ld_ret_waddr == r[ADDR_W-1:0]))
                      || (cnt_nxt_s[r] == CNT_ZERO)) begin
                lpend_nxt_s[r] = 1'b0;
            end else begin
                lpend_nxt_s[r] = lpend_r[r];
            end
        end
        tot_nxt_s = tot_r + {{(TOT_W-1){1'b0}}, |inc_s}
                          - {{(TOT_W-1){1'b0}}, |dec_s};
        err_nxt_s = err_r | (~sb.flush & (iss_err_s | ret_err_s));
    end

    // State registers; flush empties the tracking state but keeps the error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
            lpend_r <= {NREG{1'b0}};
            tot_r   <= {TOT_W{1'b0}};
            err_r   <= 1'b0;
        end else if (sb.flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
            lpend_r <= {NREG{1'b0}};
            tot_r   <= {TOT_W{1'b0}};
            err_r   <= err_r;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
            lpend_r <= lpend_nxt_s;
            tot_r   <= tot_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Hazard lookup from registered state only; no same-cycle bypass.
    always_comb begin
        hz1_s = sb.src1_used & (sb.src1_addr != ADDR_ZERO) & (cnt_r[sb.src1_addr] != CNT_ZERO);
        hz2_s = sb.src2_used & (sb.src2_addr != ADDR_ZERO) & (cnt_r[sb.src2_addr] != CNT_ZERO);
        sb.data_hazard = hz1_s | hz2_s;
        sb.load_hazard = (hz1_s & lpend_r[sb.src1_addr]) | (hz2_s & lpend_r[sb.src2_addr]);
        sb.issue_block = (sb.dst_addr != ADDR_ZERO) & (cnt_r[sb.dst_addr] == CNT_MAX);
        sb.inflight    = tot_r;
        sb.sb_err      = err_r;
    end
endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Register-dependency scoreboard that sequences the decode stage.
- Tracks every in-flight register write from decode-to-execute issue until writeback retire.
- Raises a RAW data hazard when a decoded source register still has a pending producer, and a load hazard when that producer is a load whose data has not yet returned.
- Sits beside the decode stage. Its hazard outputs gate the decode ready-go / allow-in logic and feed the load-hazard stall input of the decode stage.

Parameters:
ADDR_W, 5, register address width (number of registers = 2^ADDR_W)
CNT_W, 2, per-register pending-write counter width (max in flight per register = 2^CNT_W-1)
TOT_W, 7, width of the total in-flight write counter

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
flush  input  1  pipeline flush; discards all pending state
issue_valid  input  1  decode-to-execute handshake fired this cycle
issue_we  input  1  issued instruction writes the register file
issue_waddr  input  ADDR_W  destination register of issued instruction
issue_is_load  input  1  issued instruction is a load
ld_ret_valid  input  1  load data returned from memory this cycle
ld_ret_waddr  input  ADDR_W  destination register of returned load
retire_valid  input  1  writeback stage commits a register write this cycle
retire_waddr  input  ADDR_W  register written at writeback
src1_used  input  1  decoded instruction reads src1
src1_addr  input  ADDR_W  first source register (rj)
src2_used  input  1  decoded instruction reads src2
src2_addr  input  ADDR_W  second source register (rk or rd)
dst_addr  input  ADDR_W  destination of the instruction currently in decode
data_hazard  output  1  a used source register has a pending write
load_hazard  output  1  a used source register has a pending, unreturned load
issue_block  output  1  dst_addr counter is saturated; decode must not issue
inflight  output  TOT_W  total pending register writes
sb_err  output  1  sticky protocol-error flag

Behaviour:
- State: cnt[r] (CNT_W bits) and lpend[r] (1 bit) for each register r; tot (TOT_W bits); err (1 bit).
- Reset (resetn low, asynchronous): all cnt = 0, all lpend = 0, tot = 0, err = 0. With this state all outputs are 0.
- Register 0 is never tracked.
  - Issue or retire to r0 is ignored: no counter change, no error.
  - Source reads of r0 never produce a hazard.
- Effective issue: iss = issue_valid & issue_we & (issue_waddr != 0).
- Effective retire: ret = retire_valid & (retire_waddr != 0).
- Counter update per clock (takes effect at the next rising edge):
  - iss only: cnt[issue_waddr] +1, tot +1.
  - ret only: cnt[retire_waddr] -1, tot -1.
  - iss and ret to the same register: cnt is unchanged; tot is unchanged.
  - iss and ret to different registers: each register updated independently; tot is unchanged.
- Load tracking:
  - iss with issue_is_load=1 sets lpend[issue_waddr].
  - iss with issue_is_load=0 clears lpend[issue_waddr]; the newest producer is not a load.
  - ld_ret_valid clears lpend[ld_ret_waddr].
  - Same-cycle set and clear on the same register: the set wins.
  - ret leaving cnt = 0 also clears lpend for that register.
- Flush (synchronous): at the next edge all cnt, lpend and tot go to 0. Flush overrides any same-cycle issue, retire or load return. err is not cleared by flush.
- Outputs are purely combinational from the registered state. A producer issued in cycle t is visible to the instruction in decode at t+1; there is no same-cycle bypass.
  - hzX = srcX_used & (srcX_addr != 0) & (cnt[srcX_addr] != 0)
  - data_hazard = hz1 | hz2
  - load_hazard = (hz1 & lpend[src1_addr]) | (hz2 & lpend[src2_addr])
  - issue_block = (dst_addr != 0) & (cnt[dst_addr] == 2^CNT_W-1)
  - inflight = tot
  - sb_err = err
- Error cases (err set and sticky until reset):
  - ret to a register whose cnt = 0: that counter stays at 0 and tot does not decrement.
  - iss to a saturated register: the counter stays saturated and tot does not increment.

Test Plan:
- Reset: hold resetn low mid-operation with cnt[5]=2 -> all outputs read 0 immediately, asynchronously; after release the scoreboard is empty.
- RAW non-load: issue add to r5 at cycle 0; at cycle 1 src1_addr=5, src1_used=1 -> data_hazard=1, load_hazard=0, inflight=1; retire r5 at cycle 3 -> data_hazard=0 at cycle 4, inflight=0.
- Load hazard: issue load to r7; src2_addr=7 -> load_hazard=1; ld_ret_valid r7 -> next cycle load_hazard=0 while data_hazard=1 until retire.
- Same-cycle issue and retire on r3 with cnt[3]=1 -> cnt stays 1 and inflight unchanged. Issue to r0 or read of r0 -> no hazard, inflight unchanged.
- Saturation: three issues to r9 -> issue_block=1 for dst_addr=9; a fourth issue -> sb_err=1, inflight=3. Retire to an empty r4 -> sb_err stays 1, counters unaffected.
- Flush with issue to r6 in the same cycle and three writes pending -> next cycle inflight=0, no hazards; the r6 issue is discarded.
